// File: rtl/usb_fs_out_rr_arb_pkg.sv
// usb_fs_out_rr_arb_pkg: shared arbiter state encoding and width helper
package usb_fs_out_rr_arb_pkg;
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/usb_fs_rr_pick.sv
// usb_fs_rr_pick: circular priority picker starting at ptr
module usb_fs_rr_pick
  import usb_fs_out_rr_arb_pkg::*;
#(
  parameter int N = 1,
  parameter int IDX_W = clog2_min1(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [IDX_W-1:0] pick_idx,
  output logic             valid
);
  // first requester found scanning ptr, ptr+1, ..., wrapping back to ptr-1
  always_comb begin
    pick = '0;
    pick_idx = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && req[(int'(ptr) + i) % N]) begin
        valid = 1'b1;
        pick[(int'(ptr) + i) % N] = 1'b1;
        pick_idx = IDX_W'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/usb_fs_out_rr_arb.sv
// usb_fs_out_rr_arb: round-robin OUT endpoint arbiter with optional hold timeout
module usb_fs_out_rr_arb
  import usb_fs_out_rr_arb_pkg::*;
#(
  parameter int NUM_OUT_EPS = 1,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W = clog2_min1(NUM_OUT_EPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_OUT_EPS-1:0] out_ep_req,
  output logic [NUM_OUT_EPS-1:0] out_ep_grant,
  output logic [IDX_W-1:0]       out_ep_grant_idx,
  output logic                   out_ep_busy,
  output logic                   out_ep_timeout
);
  localparam int CNT_W = clog2_min1(MAX_HOLD + 1);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, idx_n, pick_idx, after_owner;
  logic [NUM_OUT_EPS-1:0] grant_n, pick;
  logic [CNT_W-1:0] hold_cnt, cnt_n;
  logic valid, owner_req, others, timeout_hit, timeout_n;
  usb_fs_rr_pick #(.N(NUM_OUT_EPS), .IDX_W(IDX_W)) u_pick (
    .req(out_ep_req),
    .ptr(ptr),
    .pick(pick),
    .pick_idx(pick_idx),
    .valid(valid)
  );
  assign owner_req = out_ep_req[out_ep_grant_idx];
  assign others = |(out_ep_req & ~out_ep_grant);
  assign after_owner = (out_ep_grant_idx == IDX_W'(NUM_OUT_EPS - 1)) ? '0 : out_ep_grant_idx + 1'b1;
  // >= rather than == so a saturated counter preempts as soon as a competitor shows up
  assign timeout_hit = (MAX_HOLD != 0) && (hold_cnt >= CNT_W'(MAX_HOLD - 1)) && others;
  assign out_ep_busy = |out_ep_grant;
  // next-state: grant from IDLE, release or preempt from GRANT back to IDLE
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    idx_n = out_ep_grant_idx;
    grant_n = out_ep_grant;
    cnt_n = hold_cnt;
    timeout_n = 1'b0;
    if (state == ARB_IDLE) begin
      if (valid) begin
        state_n = ARB_GRANT;
        grant_n = pick;
        idx_n = pick_idx;
        cnt_n = '0;
      end
    end else if (!owner_req || timeout_hit) begin
      state_n = ARB_IDLE;
      grant_n = '0;
      idx_n = '0;
      ptr_n = after_owner;
      timeout_n = owner_req;
    end else begin
      cnt_n = (hold_cnt == CNT_W'(MAX_HOLD)) ? hold_cnt : hold_cnt + 1'b1;
    end
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
      ptr <= '0;
      hold_cnt <= '0;
      out_ep_grant <= '0;
      out_ep_grant_idx <= '0;
      out_ep_timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      hold_cnt <= cnt_n;
      out_ep_grant <= grant_n;
      out_ep_grant_idx <= idx_n;
      out_ep_timeout <= timeout_n;
    end
  end
endmodule
